cam_pattern_gen: RTL
====================

// Module: cam_pattern_gen
// PURPOSE
//  Synthesisable camera-sensor emulator: drives an OV7670-style parallel bus
//  (pixel clock, VSYNC, HREF-style CamHsync, 8-bit bytes, RGB565 high byte first).
//  Replaces fixed constant camera stubs: resolution, blanking and pixel-clock
//  divide are parametrised, and there are four test-pattern modes.
//  Sits in front of the video capture path in simulation and on-board loopback.
// PARAMETERS
//  H_ACTIVE   640  active pixels per line
//  V_ACTIVE   480  active lines per frame
//  BPP        2    bytes per pixel (2 = RGB565; 1 = 8-bit mono)
//  H_BLANK    144  blank byte slots per line after active bytes
//  V_SYNC     3    lines with CamVsync high
//  V_BACK     12   blank lines after VSYNC
//  V_FRONT    10   blank lines after active region
//  PCLK_DIV   2    CLK cycles per byte slot; even, >=2
// PORTS
//  CLK       in   1   system clock (50 MHz); all logic on posedge
//  RST       in   1   synchronous reset, active-high
//  EN        in   1   run frames while high
//  MODE      in   2   00 const 0xA5, 01 colour bars, 10 byte ramp, 11 frame/line XOR
//  CamPclk   out  1   pixel clock: low for first PCLK_DIV/2 cycles of a slot, then high
//  CamVsync  out  1   high during V_SYNC lines
//  CamHsync  out  1   HREF: high during active byte slots of active lines
//  CamData   out  8   byte; 0x00 whenever CamHsync low
//  FrameDone out  1   one-CLK pulse at the end of the last V_FRONT line
//  FrameCnt  out  16  completed frames; wraps 0xFFFF->0x0000
// BEHAVIOUR
//  - Reset: all outputs 0. State IDLE. div/h/v/FrameCnt = 0.
//  - div counts 0..PCLK_DIV-1 continuously. tick = (div==PCLK_DIV-1).
//    CamPclk is registered (div>=PCLK_DIV/2), so it is low in IDLE only while div is low.
//  - H_TOT = H_ACTIVE*BPP + H_BLANK slots. h advances on tick, 0..H_TOT-1.
//    At wrap, v advances.
//  - FSM states: IDLE -> VSYNC(V_SYNC lines) -> VBACK(V_BACK) -> ACTIVE(V_ACTIVE)
//    -> VFRONT(V_FRONT) -> VSYNC if EN else IDLE.
//  - IDLE -> VSYNC on the first tick with EN=1; h=v=0 at entry.
//  - EN dropped mid-frame: the current frame completes, then IDLE. No truncated frame.
//  - MODE is sampled at VSYNC entry and held for the whole frame.
//  - CamVsync/CamHsync/CamData are registered and update on the CLK after tick,
//    i.e. on CamPclk falling edge. Data is stable around CamPclk rising edge.
//  - Pixel x = h/BPP, byte b = h%BPP. For BPP=2, b=0 is the high byte.
//  - Pattern bytes:
//    - MODE 00: 0xA5.
//    - MODE 01: 8 bars, bar = x*8/H_ACTIVE. RGB565 values
//      FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000. For BPP=1, the high byte is sent.
//    - MODE 10: h[7:0].
//    - MODE 11: FrameCnt[7:0] ^ active_line[7:0], where active_line counts 0..V_ACTIVE-1.
//  - FrameDone pulses and FrameCnt increments on the same CLK as the VFRONT->next transition.
//  - RST mid-frame: next CLK all outputs 0, IDLE. No FrameDone.
// STRUCTURE
//  - Shared package cam_pkg: MODE codes, FSM state encodings, RGB565 bar table.
//  - One sub-module, cam_pclk_div: div counter, tick, CamPclk.
//  - Top level: FSM, h/v counters, pattern mux.
// TESTING
//  Bench params: H_ACTIVE=8, V_ACTIVE=4, BPP=2, H_BLANK=4, V_SYNC=1, V_BACK=1,
//  V_FRONT=1, PCLK_DIV=2.
//  1 RST high 3 CLK, EN=0 -> all outputs 0; CamVsync never rises over 100 CLK.
//  2 EN=1, MODE=00 -> CamVsync high for 1 line (40 CLK); 4 lines of 16 HREF slots
//    with 0xA5; FrameDone after 7 lines (280 CLK); FrameCnt=1.
//  3 MODE=01 -> per line the bytes are FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00.
//  4 MODE changed mid-frame 00->10 -> current frame stays 0xA5;
//    next frame line bytes are 00..0F.
//  5 EN dropped during ACTIVE -> frame completes, FrameDone pulses once, then IDLE
//    with outputs low.
//  6 RST asserted mid-ACTIVE -> next CLK all outputs 0, FrameCnt=0.
//    Force FrameCnt=0xFFFF -> one frame later it wraps to 0x0000.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the camera pattern generator: test-pattern modes,
// frame-sequencer states and the RGB565 colour-bar palette.
package cam_pkg;

  typedef enum logic [1:0] {
    MODE_CONST = 2'b00,
    MODE_BARS  = 2'b01,
    MODE_RAMP  = 2'b10,
    MODE_XOR   = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_e;

  localparam logic [7:0] CONST_BYTE = 8'hA5;

  // Bars run left to right from white down to black.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cam_pclk_div.sv
// Free-running byte-slot divider: produces the slot tick and a registered
// pixel clock that is low for the first half of every slot.
module cam_pclk_div #(
  parameter int PCLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o,
  output logic pclk_o
);

  localparam int DW = $clog2(PCLK_DIV);

  logic [DW-1:0] div_q, div_d;
  logic          pclk_q;

  assign tick_o = (div_q == DW'(PCLK_DIV - 1));
  assign pclk_o = pclk_q;

  always_comb begin
    div_d = tick_o ? '0 : div_q + DW'(1);
  end

  // The clock register follows the counter it is derived from, so it always equals div >= half.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q  <= '0;
      pclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      pclk_q <= (div_d >= DW'(PCLK_DIV / 2));
    end
  end

endmodule

// File: rtl/cam_pattern_gen.sv
// OV7670-style parallel camera emulator: frame sequencer, line/slot counters
// and a four-mode test-pattern generator on top of the byte-slot divider.
module cam_pattern_gen
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BPP      = 2,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 12,
  parameter int V_FRONT  = 10,
  parameter int PCLK_DIV = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [1:0]  MODE,
  output logic        CamPclk,
  output logic        CamVsync,
  output logic        CamHsync,
  output logic [7:0]  CamData,
  output logic        FrameDone,
  output logic [15:0] FrameCnt
);

  localparam int H_BYTES = H_ACTIVE * BPP;
  localparam int H_TOT   = H_BYTES + H_BLANK;

  logic        tick;
  state_e      state_q, state_d;
  mode_e       mode_q, mode_d;
  logic [15:0] h_q, h_d, v_q, v_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        done_q, done_d;
  logic        vsync_q, vsync_d, hsync_q, hsync_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] state_lines;
  logic        line_end, last_line;
  logic [15:0] pix_x;
  logic [2:0]  bar_idx;
  logic [15:0] bar_rgb;
  logic        lo_byte;

  cam_pclk_div #(.PCLK_DIV(PCLK_DIV)) u_div (
    .clk_i  (CLK),
    .rst_i  (RST),
    .tick_o (tick),
    .pclk_o (CamPclk)
  );

  assign CamVsync  = vsync_q;
  assign CamHsync  = hsync_q;
  assign CamData   = data_q;
  assign FrameDone = done_q;
  assign FrameCnt  = frame_cnt_q;

  always_comb begin
    case (state_q)
      ST_VSYNC:  state_lines = 16'(V_SYNC);
      ST_VBACK:  state_lines = 16'(V_BACK);
      ST_ACTIVE: state_lines = 16'(V_ACTIVE);
      ST_VFRONT: state_lines = 16'(V_FRONT);
      default:   state_lines = 16'd1;
    endcase
  end

  assign line_end  = (h_q == 16'(H_TOT - 1));
  assign last_line = (v_q == state_lines - 16'd1);

  // Everything advances only on slot ticks; a frame always runs to its end before EN is looked at again.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    h_d         = h_q;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    if (tick) begin
      if (state_q == ST_IDLE) begin
        if (EN) begin
          state_d = ST_VSYNC;
          mode_d  = mode_e'(MODE);
          h_d     = '0;
          v_d     = '0;
        end
      end else if (!line_end) begin
        h_d = h_q + 16'd1;
      end else begin
        h_d = '0;
        if (!last_line) begin
          v_d = v_q + 16'd1;
        end else begin
          v_d = '0;
          case (state_q)
            ST_VSYNC:  state_d = ST_VBACK;
            ST_VBACK:  state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_VFRONT;
            default: begin
              done_d      = 1'b1;
              frame_cnt_d = frame_cnt_q + 16'd1;
              if (EN) begin
                state_d = ST_VSYNC;
                mode_d  = mode_e'(MODE);
              end else begin
                state_d = ST_IDLE;
              end
            end
          endcase
        end
      end
    end
  end

  // Bus values are derived from the slot being entered, so they change with the falling CamPclk.
  always_comb begin
    pix_x   = h_d / 16'(BPP);
    bar_idx = 3'((32'(pix_x) * 32'd8) / 32'(H_ACTIVE));
    bar_rgb = bar_color(bar_idx);
    lo_byte = (BPP == 2) && h_d[0];
    vsync_d = (state_d == ST_VSYNC);
    hsync_d = (state_d == ST_ACTIVE) && (h_d < 16'(H_BYTES));
    data_d  = 8'h00;
    if (hsync_d) begin
      case (mode_d)
        MODE_CONST: data_d = CONST_BYTE;
        MODE_BARS:  data_d = lo_byte ? bar_rgb[7:0] : bar_rgb[15:8];
        MODE_RAMP:  data_d = h_d[7:0];
        default:    data_d = frame_cnt_q[7:0] ^ v_d[7:0];
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_CONST;
      h_q         <= '0;
      v_q         <= '0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      vsync_q     <= 1'b0;
      hsync_q     <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      h_q         <= h_d;
      v_q         <= v_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
      vsync_q     <= vsync_d;
      hsync_q     <= hsync_d;
      data_q      <= data_d;
    end
  end

endmodule
